iter_right_shifter: RTL and testbench

- Multi-cycle right-shift unit alongside the single-cycle ALU in the CPU datapath.
- Covers the right-shift direction that the ALU's left shifts (SLL/SLLV/LUI) do not: SRL, SRA, SRLV, SRAV.
- Shifts one bit per clock under a start/busy/done handshake.
- Exposes the same result_o/zero_o pair as the ALU, so the writeback mux treats the two units alike.

---
 rtl/iter_right_shifter.sv | 157 +++++++++++++++
 tb/tb_iter_right_shifter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/iter_right_shifter.sv
// ---------------------------------------------------------------------------
// iter_right_shifter
//
// Multi-cycle right-shift unit that sits beside the single-cycle ALU. It
// handles SRL, SRA, SRLV and SRAV and shifts one bit per clock.
//
// Handshake: start_i is accepted in IDLE or DONE. busy_o is high while
// shifting. done_o pulses for one cycle when the result is ready. A new
// start_i may be issued in the DONE cycle, so there is no idle bubble.
//
// Ports:
//   clk_i     rising-edge clock
//   rst_i     synchronous, active-high reset
//   start_i   request pulse, sampled only in IDLE or DONE
//   ctrl_i    operation select, sampled with start_i
//   src1_i    rs value; bits [SHW-1:0] give the amount for SRLV/SRAV
//   src2_i    rt value, the operand that is shifted
//   shamt_i   instruction shamt field; the amount for SRL/SRA
//   result_o  last completed result, registered
//   zero_o    result_o == 0
//   busy_o    high while shifting
//   done_o    one-cycle completion pulse
// ---------------------------------------------------------------------------
module iter_right_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [SHW-1:0]   shamt_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [3:0] CTRL_SRL  = 4'b0110;
    localparam logic [3:0] CTRL_SRA  = 4'b0111;
    localparam logic [3:0] CTRL_SRLV = 4'b1000;
    localparam logic [3:0] CTRL_SRAV = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [SHW-1:0]   count_q,  count_d;
    logic             arith_q,  arith_d;

    logic [SHW-1:0]   amount;
    logic             arith_sel;
    logic [WIDTH-1:0] shifted;
    logic [SHW-1:0]   count_dec;

    // Only the low bits of rs carry the variable shift amount.
    logic unused_src1;
    assign unused_src1 = ^src1_i[WIDTH-1:SHW];

    // One-bit right shift; the sign bit is replicated for arithmetic shifts.
    function automatic logic [WIDTH-1:0] shr1(input logic [WIDTH-1:0] v,
                                              input logic             arith);
        logic signed [WIDTH-1:0] sv;
        sv = v;
        if (arith) begin
            return sv >>> 1;
        end
        return v >> 1;
    endfunction

    // Decode the shift amount and fill mode of the requested operation.
    // Unknown codes fall through with amount 0, returning src2_i unchanged.
    always_comb begin
        amount    = '0;
        arith_sel = 1'b0;
        case (ctrl_i)
            CTRL_SRL:  amount = shamt_i;
            CTRL_SRA: begin
                amount    = shamt_i;
                arith_sel = 1'b1;
            end
            CTRL_SRLV: amount = src1_i[SHW-1:0];
            CTRL_SRAV: begin
                amount    = src1_i[SHW-1:0];
                arith_sel = 1'b1;
            end
            default: amount = '0;
        endcase
    end

    assign shifted   = shr1(shadow_q, arith_q);
    assign count_dec = count_q - SHW'(1);

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        result_d = result_q;
        count_d  = count_q;
        arith_d  = arith_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    shadow_d = src2_i;
                    count_d  = amount;
                    arith_d  = arith_sel;
                    if (amount == '0) begin
                        // Zero-length shift completes on the start edge.
                        result_d = src2_i;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shadow_d = shifted;
                count_d  = count_dec;
                if (count_dec == '0) begin
                    result_d = shifted;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            result_q <= '0;
            count_q  <= '0;
            arith_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            result_q <= result_d;
            count_q  <= count_d;
            arith_q  <= arith_d;
        end
    end

    assign result_o = result_q;
    assign zero_o   = (result_q == '0);
    assign busy_o   = (state_q == ST_SHIFT);
    assign done_o   = (state_q == ST_DONE);

endmodule

// File: tb/tb_iter_right_shifter.sv
// ---------------------------------------------------------------------------
// tb_iter_right_shifter
//
// Directed bench for iter_right_shifter. Inputs change on the falling edge
// and outputs are sampled on the falling edge, half a period away from the
// active rising edge.
// ---------------------------------------------------------------------------
module tb_iter_right_shifter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [3:0]  ctrl_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic [4:0]  shamt_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic        busy_o;
    logic        done_o;

    int checks   = 0;
    int failures = 0;

    int lat;
    int busy_cnt;
    logic seen_done;

    iter_right_shifter #(.WIDTH(32), .SHW(5)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .ctrl_i   (ctrl_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .shamt_i  (shamt_i),
        .result_o (result_o),
        .zero_o   (zero_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request for one rising edge; returns in the cycle after it.
    task automatic issue(input logic [3:0] c, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [4:0] sh);
        ctrl_i  = c;
        src1_i  = s1;
        src2_i  = s2;
        shamt_i = sh;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Wait (bounded) for done_o; lat counts cycles past the first post-start cycle.
    task automatic wait_done();
        lat      = 0;
        busy_cnt = 0;
        while (!done_o && lat < 64) begin
            if (busy_o) busy_cnt++;
            @(negedge clk_i);
            lat++;
        end
    endtask

    initial begin
        rst_i   = 1'b1;
        start_i = 1'b0;
        ctrl_i  = 4'b0000;
        src1_i  = '0;
        src2_i  = '0;
        shamt_i = '0;
        repeat (2) @(negedge clk_i);

        // Reset with a simultaneous start request: reset wins.
        start_i = 1'b1;
        ctrl_i  = 4'b0110;
        shamt_i = 5'd4;
        src2_i  = 32'hF000_0000;
        @(negedge clk_i);
        chk("rst_result", result_o, 32'h0);
        chk("rst_zero", {31'b0, zero_o}, 32'h1);
        chk("rst_busy", {31'b0, busy_o}, 32'h0);
        chk("rst_done", {31'b0, done_o}, 32'h0);
        rst_i   = 1'b0;
        start_i = 1'b0;
        @(negedge clk_i);
        chk("idle_busy", {31'b0, busy_o}, 32'h0);
        chk("idle_done", {31'b0, done_o}, 32'h0);

        // SRL by 4.
        issue(4'b0110, 32'h0, 32'hF000_0000, 5'd4);
        chk("srl_hold_result", result_o, 32'h0);
        wait_done();
        chk("srl_latency", lat, 4);
        chk("srl_busy_cycles", busy_cnt, 4);
        chk("srl_result", result_o, 32'h0F00_0000);
        chk("srl_zero", {31'b0, zero_o}, 32'h0);
        @(negedge clk_i);
        chk("srl_done_pulse", {31'b0, done_o}, 32'h0);

        // SRAV by 31 (upper bits of src1 ignored).
        issue(4'b1001, 32'hFFFF_FF1F, 32'h8000_0000, 5'd0);
        chk("srav_hold_result", result_o, 32'h0F00_0000);
        wait_done();
        chk("srav_latency", lat, 31);
        chk("srav_result", result_o, 32'hFFFF_FFFF);
        @(negedge clk_i);

        // SRLV by 31.
        issue(4'b1000, 32'hFFFF_FF1F, 32'h8000_0000, 5'd0);
        wait_done();
        chk("srlv_latency", lat, 31);
        chk("srlv_result", result_o, 32'h0000_0001);
        @(negedge clk_i);

        // SRA by 0 completes immediately.
        issue(4'b0111, 32'h0, 32'h8000_0001, 5'd0);
        wait_done();
        chk("sra0_latency", lat, 0);
        chk("sra0_busy_cycles", busy_cnt, 0);
        chk("sra0_busy_now", {31'b0, busy_o}, 32'h0);
        chk("sra0_result", result_o, 32'h8000_0001);
        @(negedge clk_i);

        // Input changes during SHIFT are ignored.
        issue(4'b0110, 32'h0, 32'h0000_FF00, 5'd8);
        repeat (2) @(negedge clk_i);
        start_i = 1'b1;
        ctrl_i  = 4'b1001;
        src1_i  = 32'h0000_0003;
        src2_i  = 32'hDEAD_BEEF;
        shamt_i = 5'd1;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_done();
        chk("mid_latency", lat, 5);
        chk("mid_result", result_o, 32'h0000_00FF);
        @(negedge clk_i);

        // Reset during SHIFT abandons the operation.
        issue(4'b0110, 32'h0, 32'h0000_FF00, 5'd8);
        repeat (4) @(negedge clk_i);
        chk("abort_busy_before", {31'b0, busy_o}, 32'h1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("abort_result", result_o, 32'h0);
        chk("abort_zero", {31'b0, zero_o}, 32'h1);
        chk("abort_busy", {31'b0, busy_o}, 32'h0);
        seen_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done_o || busy_o) seen_done = 1'b1;
            @(negedge clk_i);
        end
        chk("abort_no_done", {31'b0, seen_done}, 32'h0);

        // Back-to-back issue: SRL 1 then SRA 1 started in the DONE cycle.
        issue(4'b0110, 32'h0, 32'h0000_0002, 5'd1);
        chk("b2b_busy1", {31'b0, busy_o}, 32'h1);
        @(negedge clk_i);
        chk("b2b_done1", {31'b0, done_o}, 32'h1);
        chk("b2b_result1", result_o, 32'h0000_0001);
        issue(4'b0111, 32'h0, 32'h8000_0000, 5'd1);
        chk("b2b_busy2", {31'b0, busy_o}, 32'h1);
        chk("b2b_nodone2", {31'b0, done_o}, 32'h0);
        @(negedge clk_i);
        chk("b2b_done2", {31'b0, done_o}, 32'h1);
        chk("b2b_result2", result_o, 32'hC000_0000);
        @(negedge clk_i);

        // Unknown control code passes src2 through with no shift.
        issue(4'b0000, 32'hFFFF_FFFF, 32'h0, 5'd7);
        chk("inv_done", {31'b0, done_o}, 32'h1);
        chk("inv_result", result_o, 32'h0);
        chk("inv_zero", {31'b0, zero_o}, 32'h1);
        @(negedge clk_i);
        chk("inv_idle_done", {31'b0, done_o}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
